bcd_stopwatch_mux: RTL and testbench

//  Parametrised N-digit BCD stopwatch/counter with a multiplexed 7-segment driver.

---
 rtl/bcd_stopwatch_mux.sv | 222 ++++++++++++++++++++++
 tb/tb_bcd_stopwatch_mux.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch_mux.sv
// N-digit BCD stopwatch with debounced run/clear buttons and a multiplexed,
// registered 7-segment driver (active-low anodes and cathodes).

module bcd_stopwatch_debounce #(
  parameter int DB_CYCLES = 1000000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn,
  output logic press_p
);
  localparam int CNT_W = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DB_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_MAX) level_d = sync2_q;
      else                  cnt_d   = cnt_q + 1'b1;
    end
    press_d = level_d & ~level_q;
  end

  // Synchroniser and level reset high so a button held through reset release
  // cannot produce a press until it has been released and pressed again.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      level_q <= 1'b1;
      cnt_q   <= '0;
      press_q <= 1'b0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
      press_q <= press_d;
    end
  end

  assign press_p = press_q;
endmodule

module bcd_stopwatch_mux #(
  parameter int NUM_DIGITS   = 4,
  parameter int TICK_DIV     = 100000,
  parameter int REFRESH_BITS = 18,
  parameter int DB_CYCLES    = 1000000,
  parameter bit WRAP         = 1'b0,
  parameter bit BLANK_LZ     = 1'b0
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  btn_run,
  input  logic                  btn_clear,
  input  logic                  dir,
  output logic [NUM_DIGITS-1:0] an,
  output logic [6:0]            sseg,
  output logic                  running,
  output logic                  at_limit
);
  localparam int PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int SLOT_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam int RF_W   = REFRESH_BITS + SLOT_W;
  localparam logic [PRE_W-1:0] PRE_MAX   = PRE_W'(TICK_DIV - 1);
  localparam logic [SLOT_W:0]  NUM_DIG_L = (SLOT_W + 1)'(NUM_DIGITS);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  state_t                      state_q, state_d;
  logic [NUM_DIGITS-1:0][3:0]  digits_q, digits_d;
  logic [NUM_DIGITS-1:0][3:0]  up_val, dn_val;
  logic [PRE_W-1:0]            pre_q, pre_d;
  logic [RF_W-1:0]             refresh_q, refresh_d, refresh_inc;
  logic [SLOT_W-1:0]           slot;
  logic [NUM_DIGITS-1:0]       upper_zero;
  logic [NUM_DIGITS-1:0]       an_q, an_d;
  logic [6:0]                  sseg_q, sseg_d;
  logic                        running_q, running_d;
  logic                        at_limit_q, at_limit_d;
  logic                        run_p, clear_p, tick;
  logic                        carry, borrow, all_nine, all_zero, zero_above;

  bcd_stopwatch_debounce #(.DB_CYCLES(DB_CYCLES)) u_run_db (
    .clk(clk), .reset(reset), .btn(btn_run), .press_p(run_p)
  );

  bcd_stopwatch_debounce #(.DB_CYCLES(DB_CYCLES)) u_clear_db (
    .clk(clk), .reset(reset), .btn(btn_clear), .press_p(clear_p)
  );

  function automatic logic [6:0] seg_pattern(input logic [3:0] d);
    case (d)
      4'd0:    seg_pattern = 7'b1000000;
      4'd1:    seg_pattern = 7'b1111001;
      4'd2:    seg_pattern = 7'b0100100;
      4'd3:    seg_pattern = 7'b0110000;
      4'd4:    seg_pattern = 7'b0011001;
      4'd5:    seg_pattern = 7'b0010010;
      4'd6:    seg_pattern = 7'b0000010;
      4'd7:    seg_pattern = 7'b1111000;
      4'd8:    seg_pattern = 7'b0000000;
      4'd9:    seg_pattern = 7'b0010000;
      default: seg_pattern = 7'b1111111;
    endcase
  endfunction

  // Both neighbour values in one cycle; a rolled-over value is the wrap target.
  always_comb begin
    carry  = 1'b1;
    borrow = 1'b1;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      up_val[i] = digits_q[i];
      dn_val[i] = digits_q[i];
      if (carry) begin
        if (digits_q[i] == 4'd9) up_val[i] = 4'd0;
        else begin
          up_val[i] = digits_q[i] + 4'd1;
          carry     = 1'b0;
        end
      end
      if (borrow) begin
        if (digits_q[i] == 4'd0) dn_val[i] = 4'd9;
        else begin
          dn_val[i] = digits_q[i] - 4'd1;
          borrow    = 1'b0;
        end
      end
    end
    all_nine = carry;
    all_zero = borrow;
  end

  always_comb begin
    state_d  = state_q;
    digits_d = digits_q;
    pre_d    = pre_q;
    tick     = (state_q == RUN) && (pre_q == PRE_MAX);
    if (clear_p) begin
      state_d  = IDLE;
      digits_d = '0;
      pre_d    = '0;
    end else begin
      unique case (state_q)
        IDLE:  if (run_p) state_d = RUN;
        RUN: begin
          pre_d = tick ? '0 : pre_q + 1'b1;
          if (tick) begin
            if (!dir) begin
              if (all_nine && !WRAP) state_d  = DONE;
              else                   digits_d = up_val;
            end else begin
              if (all_zero && !WRAP) state_d  = DONE;
              else                   digits_d = dn_val;
            end
          end
          if (run_p && (state_d == RUN)) state_d = PAUSE;
        end
        PAUSE: if (run_p) state_d = RUN;
        DONE:  state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
    running_d  = (state_d == RUN);
    at_limit_d = (state_d == DONE);
  end

  always_comb begin
    zero_above = 1'b1;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      zero_above    = zero_above & (digits_q[i] == 4'd0);
      upper_zero[i] = zero_above;
    end
  end

  assign slot = refresh_q[REFRESH_BITS +: SLOT_W];

  // Slot field past the last digit restarts the scan for non power-of-two counts.
  always_comb begin
    refresh_inc = refresh_q + 1'b1;
    refresh_d   = refresh_inc;
    if ({1'b0, refresh_inc[REFRESH_BITS +: SLOT_W]} >= NUM_DIG_L) refresh_d = '0;
    an_d        = '1;
    an_d[slot]  = 1'b0;
    sseg_d      = seg_pattern(digits_q[slot]);
    if (BLANK_LZ && (slot != '0) && upper_zero[slot]) sseg_d = 7'b1111111;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= IDLE;
      digits_q   <= '0;
      pre_q      <= '0;
      refresh_q  <= '0;
      an_q       <= '1;
      sseg_q     <= 7'b1111111;
      running_q  <= 1'b0;
      at_limit_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      digits_q   <= digits_d;
      pre_q      <= pre_d;
      refresh_q  <= refresh_d;
      an_q       <= an_d;
      sseg_q     <= sseg_d;
      running_q  <= running_d;
      at_limit_q <= at_limit_d;
    end
  end

  assign an       = an_q;
  assign sseg     = sseg_q;
  assign running  = running_q;
  assign at_limit = at_limit_q;
endmodule

// File: tb/tb_bcd_stopwatch_mux.sv
// Directed bench: dut_a saturates (WRAP=0), dut_b wraps and blanks leading zeros.

module tb_bcd_stopwatch_mux;
  logic       clk, reset;
  logic       run_a, clear_a, dir_a, running_a, limit_a;
  logic       run_b, clear_b, dir_b, running_b, limit_b;
  logic [1:0] an_a, an_b;
  logic [6:0] sseg_a, sseg_b;
  int         checks, errors;

  bcd_stopwatch_mux #(.NUM_DIGITS(2), .TICK_DIV(4), .REFRESH_BITS(2), .DB_CYCLES(3),
                      .WRAP(1'b0), .BLANK_LZ(1'b0)) dut_a (
    .clk(clk), .reset(reset), .btn_run(run_a), .btn_clear(clear_a), .dir(dir_a),
    .an(an_a), .sseg(sseg_a), .running(running_a), .at_limit(limit_a)
  );

  bcd_stopwatch_mux #(.NUM_DIGITS(2), .TICK_DIV(4), .REFRESH_BITS(2), .DB_CYCLES(3),
                      .WRAP(1'b1), .BLANK_LZ(1'b1)) dut_b (
    .clk(clk), .reset(reset), .btn_run(run_b), .btn_clear(clear_b), .dir(dir_b),
    .an(an_b), .sseg(sseg_b), .running(running_b), .at_limit(limit_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick_n(input int n);
    repeat (n) @(negedge clk);
  endtask

  // 0: run_a, 1: clear_a, 2: run_b, 3: clear_a and run_a together
  task automatic press(input int which);
    case (which)
      0: run_a = 1'b1;
      1: clear_a = 1'b1;
      2: run_b = 1'b1;
      default: begin run_a = 1'b1; clear_a = 1'b1; end
    endcase
    tick_n(6);
    run_a = 1'b0; clear_a = 1'b0; run_b = 1'b0;
    tick_n(10);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    run_a = 1'b0; clear_a = 1'b0; dir_a = 1'b0;
    run_b = 1'b0; clear_b = 1'b0; dir_b = 1'b0;
    tick_n(3);
    checks++; if (an_a !== 2'b11) begin errors++; $display("[TB] FAIL reset_an: got %b expected 11", an_a); end
    checks++; if (sseg_a !== 7'b1111111) begin errors++; $display("[TB] FAIL reset_sseg: got %b expected 1111111", sseg_a); end
    checks++; if (running_a !== 1'b0 || limit_a !== 1'b0) begin errors++; $display("[TB] FAIL reset_flags: got %b%b expected 00", running_a, limit_a); end
    checks++; if (dut_a.digits_q !== 8'h00) begin errors++; $display("[TB] FAIL reset_digits: got %h expected 00", dut_a.digits_q); end
    checks++; if (an_b !== 2'b11) begin errors++; $display("[TB] FAIL reset_an_b: got %b expected 11", an_b); end
    reset = 1'b1;
    tick_n(12);
  endtask

  task automatic test_count_up();
    int n;
    n = 0;
    run_a = 1'b1;
    while (running_a !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    run_a = 1'b0;
    checks++; if (running_a !== 1'b1) begin errors++; $display("[TB] FAIL run_start: got %b expected 1", running_a); end
    tick_n(3);
    checks++; if (dut_a.digits_q !== 8'h00) begin errors++; $display("[TB] FAIL step_early: got %h expected 00", dut_a.digits_q); end
    tick_n(1);
    checks++; if (dut_a.digits_q !== 8'h01) begin errors++; $display("[TB] FAIL step_first: got %h expected 01", dut_a.digits_q); end
    tick_n(155);
    checks++; if (dut_a.digits_q !== 8'h39) begin errors++; $display("[TB] FAIL count_39: got %h expected 39", dut_a.digits_q); end
    tick_n(1);
    checks++; if (dut_a.digits_q !== 8'h40) begin errors++; $display("[TB] FAIL count_40: got %h expected 40", dut_a.digits_q); end
  endtask

  task automatic test_saturate();
    int n;
    n = 0;
    while (dut_a.digits_q !== 8'h95 && n < 300) begin @(negedge clk); n++; end
    checks++; if (dut_a.digits_q !== 8'h95) begin errors++; $display("[TB] FAIL reach_95: got %h expected 95", dut_a.digits_q); end
    n = 0;
    while (limit_a !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++; if (limit_a !== 1'b1 || running_a !== 1'b0) begin errors++; $display("[TB] FAIL done_flags: got limit=%b run=%b expected 1 0", limit_a, running_a); end
    checks++; if (dut_a.digits_q !== 8'h99) begin errors++; $display("[TB] FAIL done_hold: got %h expected 99", dut_a.digits_q); end
    tick_n(20);
    checks++; if (dut_a.digits_q !== 8'h99) begin errors++; $display("[TB] FAIL done_still: got %h expected 99", dut_a.digits_q); end
    press(0);
    checks++; if (limit_a !== 1'b1 || running_a !== 1'b0) begin errors++; $display("[TB] FAIL done_ignore_run: got limit=%b run=%b expected 1 0", limit_a, running_a); end
    press(1);
    checks++; if (dut_a.digits_q !== 8'h00 || limit_a !== 1'b0 || running_a !== 1'b0) begin errors++; $display("[TB] FAIL done_clear: got %h l=%b r=%b expected 00 0 0", dut_a.digits_q, limit_a, running_a); end
  endtask

  task automatic test_pause_resume();
    int n;
    logic [1:0] prev, cur;
    logic [6:0] exp_seg;
    press(0);
    checks++; if (running_a !== 1'b1) begin errors++; $display("[TB] FAIL restart: got %b expected 1", running_a); end
    n = 0;
    while (dut_a.digits_q !== 8'h36 && n < 200) begin @(negedge clk); n++; end
    run_a = 1'b1;
    tick_n(6);
    run_a = 1'b0;
    tick_n(100);
    checks++; if (dut_a.digits_q !== 8'h37 || running_a !== 1'b0) begin errors++; $display("[TB] FAIL pause_hold: got %h r=%b expected 37 0", dut_a.digits_q, running_a); end
    n = 0;
    run_a = 1'b1;
    while (running_a !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    run_a = 1'b0;
    tick_n(1);
    checks++; if (dut_a.digits_q !== 8'h37) begin errors++; $display("[TB] FAIL resume_early: got %h expected 37", dut_a.digits_q); end
    tick_n(2);
    checks++; if (dut_a.digits_q !== 8'h38) begin errors++; $display("[TB] FAIL resume_phase: got %h expected 38", dut_a.digits_q); end
    // park at 42 for the display scan
    n = 0;
    while (dut_a.digits_q !== 8'h41 && n < 40) begin @(negedge clk); n++; end
    run_a = 1'b1;
    tick_n(6);
    run_a = 1'b0;
    tick_n(8);
    checks++; if (dut_a.digits_q !== 8'h42 || running_a !== 1'b0) begin errors++; $display("[TB] FAIL park_42: got %h r=%b expected 42 0", dut_a.digits_q, running_a); end
    prev = an_a;
    n = 0;
    while (an_a === prev && n < 12) begin @(negedge clk); n++; end
    cur = an_a;
    for (int k = 0; k < 5; k++) begin
      if (k == 4) begin tick_n(1); cur = ~cur; end
      else if (k > 0) tick_n(1);
      exp_seg = (cur == 2'b10) ? 7'b0100100 : 7'b0011001;
      checks++; if (an_a !== cur || sseg_a !== exp_seg) begin errors++; $display("[TB] FAIL mux_%0d: got an=%b sseg=%b expected an=%b sseg=%b", k, an_a, sseg_a, cur, exp_seg); end
    end
  endtask

  task automatic test_bounce();
    press(1);
    checks++; if (dut_a.digits_q !== 8'h00 || running_a !== 1'b0) begin errors++; $display("[TB] FAIL clear_pause: got %h r=%b expected 00 0", dut_a.digits_q, running_a); end
    for (int i = 0; i < 10; i++) begin
      run_a = ~run_a;
      tick_n(1);
    end
    run_a = 1'b1;
    tick_n(6);
    run_a = 1'b0;
    tick_n(10);
    checks++; if (running_a !== 1'b1) begin errors++; $display("[TB] FAIL bounce_one_pulse: got %b expected 1", running_a); end
    tick_n(20);
    press(3);
    checks++; if (dut_a.digits_q !== 8'h00 || running_a !== 1'b0 || limit_a !== 1'b0) begin errors++; $display("[TB] FAIL clear_wins: got %h r=%b l=%b expected 00 0 0", dut_a.digits_q, running_a, limit_a); end
  endtask

  task automatic test_wrap_blank();
    int n;
    int seen0, seen1;
    logic [6:0] exp_seg;
    dir_b = 1'b1;
    run_b = 1'b1;
    n = 0;
    while (running_b !== 1'b1 && n < 30) begin @(negedge clk); n++; end
    run_b = 1'b0;
    tick_n(3);
    checks++; if (dut_b.digits_q !== 8'h00) begin errors++; $display("[TB] FAIL wrap_early: got %h expected 00", dut_b.digits_q); end
    tick_n(1);
    checks++; if (dut_b.digits_q !== 8'h99 || running_b !== 1'b1) begin errors++; $display("[TB] FAIL wrap_down: got %h r=%b expected 99 1", dut_b.digits_q, running_b); end
    dir_b = 1'b0;
    tick_n(4);
    checks++; if (dut_b.digits_q !== 8'h00 || running_b !== 1'b1) begin errors++; $display("[TB] FAIL wrap_up: got %h r=%b expected 00 1", dut_b.digits_q, running_b); end
    n = 0;
    while (dut_b.digits_q !== 8'h04 && n < 40) begin @(negedge clk); n++; end
    run_b = 1'b1;
    tick_n(6);
    run_b = 1'b0;
    tick_n(8);
    checks++; if (dut_b.digits_q !== 8'h05 || running_b !== 1'b0) begin errors++; $display("[TB] FAIL park_05: got %h r=%b expected 05 0", dut_b.digits_q, running_b); end
    seen0 = 0; seen1 = 0;
    for (int i = 0; i < 8; i++) begin
      tick_n(1);
      if (an_b == 2'b10) begin exp_seg = 7'b0010010; seen0++; end
      else begin exp_seg = 7'b1111111; seen1++; end
      checks++; if ((an_b !== 2'b10 && an_b !== 2'b01) || sseg_b !== exp_seg) begin errors++; $display("[TB] FAIL blank_%0d: got an=%b sseg=%b expected sseg=%b", i, an_b, sseg_b, exp_seg); end
    end
    checks++; if (seen0 == 0 || seen1 == 0) begin errors++; $display("[TB] FAIL blank_scan: got slot0=%0d slot1=%0d expected both nonzero", seen0, seen1); end
  endtask

  task automatic test_reset_mid();
    press(2);
    checks++; if (running_b !== 1'b1) begin errors++; $display("[TB] FAIL mid_run: got %b expected 1", running_b); end
    tick_n(9);
    reset = 1'b0;
    #1;
    checks++; if (running_b !== 1'b0 || dut_b.digits_q !== 8'h00 || an_b !== 2'b11 || sseg_b !== 7'b1111111) begin errors++; $display("[TB] FAIL async_reset: got r=%b d=%h an=%b sseg=%b expected 0 00 11 1111111", running_b, dut_b.digits_q, an_b, sseg_b); end
    run_b = 1'b1;
    tick_n(3);
    reset = 1'b1;
    tick_n(20);
    checks++; if (running_b !== 1'b0) begin errors++; $display("[TB] FAIL held_release: got %b expected 0", running_b); end
    run_b = 1'b0;
    tick_n(10);
    press(2);
    checks++; if (running_b !== 1'b1) begin errors++; $display("[TB] FAIL repress: got %b expected 1", running_b); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_count_up();
    test_saturate();
    test_pause_resume();
    test_bounce();
    test_wrap_blank();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
